// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and constants for the real-time clock core.
// Holds the set-mode select encoding, field limits and field widths.
package rtc_pkg;

    typedef enum logic [1:0] {
        RTC_RUN      = 2'd0,
        RTC_SET_SEC  = 2'd1,
        RTC_SET_MIN  = 2'd2,
        RTC_SET_HOUR = 2'd3
    } rtc_sel_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // An edit is valid only when exactly one of inc/dec is pulsed.
    function automatic logic is_edit(input logic i_inc, input logic i_dec);
        return i_inc ^ i_dec;
    endfunction

endpackage

// File: rtl/rtc_wrap_cnt.sv
// rtc_wrap_cnt: modulo-(MAX+1) up/down counter with wrap in both directions.
// Ports: clk, rst (async active-low), i_en (step enable), i_up, i_down,
//        o_q (registered count), o_carry (MAX->0 on an up step).
module rtc_wrap_cnt #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_up,
    input  logic         i_down,
    output logic [W-1:0] o_q,
    output logic         o_carry
);

    localparam logic [W-1:0] LP_MAX = W'(MAX);

    logic [W-1:0] r_q;
    logic         w_up;
    logic         w_dn;
    logic         w_at_max;
    logic         w_at_zero;

    // Up and down together cancel out.
    assign w_up      = i_en & i_up & ~i_down;
    assign w_dn      = i_en & i_down & ~i_up;
    assign w_at_max  = (r_q == LP_MAX);
    assign w_at_zero = (r_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (w_up) begin
            r_q <= w_at_max ? '0 : r_q + W'(1);
        end else if (w_dn) begin
            r_q <= w_at_zero ? LP_MAX : r_q - W'(1);
        end
    end

    assign o_q     = r_q;
    assign o_carry = w_up & w_at_max;

endmodule

// File: rtl/rtc_core.sv
// rtc_core: 1 Hz timebase plus sec/min/hour/day keeping with a set mode.
// Ports: clk, rst (async active-low), run, sel, inc, dec -> sec, min, hour,
//        day, tick_1hz, day_wrap. Optional alarm (RTC_ALARM_EN) adds
//        alarm_en, alarm_hour, alarm_min -> alarm. All outputs are flops.
module rtc_core
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int DAY_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [1:0]        sel,
    input  logic              inc,
    input  logic              dec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [DAY_W-1:0]  day,
    output logic              tick_1hz,
    output logic              day_wrap
`ifdef RTC_ALARM_EN
    ,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    output logic              alarm
`endif
);

    localparam int               PS_W  = $clog2(CLK_FREQ_HZ);
    localparam logic [PS_W-1:0]  PS_TC = PS_W'(CLK_FREQ_HZ - 1);

    rtc_sel_e          w_sel;
    logic              w_run_mode;
    logic              w_tick;
    logic              w_edit;
    logic              w_ed_sec;
    logic              w_ed_min;
    logic              w_ed_hour;
    logic              w_sec_co;
    logic              w_min_co;
    logic              w_hour_co;
    logic              w_sec_c;
    logic              w_min_c;
    logic              w_hour_c;
    logic [SEC_W-1:0]  w_sec;
    logic [MIN_W-1:0]  w_min;
    logic [HOUR_W-1:0] w_hour;

    logic [PS_W-1:0]   r_ps;
    logic [DAY_W-1:0]  r_day;
    logic              r_tick;
    logic              r_wrap;

    assign w_sel      = rtc_sel_e'(sel);
    assign w_run_mode = (w_sel == RTC_RUN);
    assign w_tick     = w_run_mode & run & (r_ps == PS_TC);

    assign w_edit    = ~w_run_mode & is_edit(inc, dec);
    assign w_ed_sec  = w_edit & (w_sel == RTC_SET_SEC);
    assign w_ed_min  = w_edit & (w_sel == RTC_SET_MIN);
    assign w_ed_hour = w_edit & (w_sel == RTC_SET_HOUR);

    // Carries only ripple on a timebase tick; a set-mode wrap stays local.
    assign w_sec_c  = w_sec_co & w_tick;
    assign w_min_c  = w_min_co & w_tick;
    assign w_hour_c = w_hour_co & w_tick;

    // Set mode pins the prescaler to 0 so the first tick after leaving
    // comes a full period later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ps <= '0;
        end else if (!w_run_mode) begin
            r_ps <= '0;
        end else if (run) begin
            r_ps <= w_tick ? '0 : r_ps + PS_W'(1);
        end
    end

    rtc_wrap_cnt #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_tick | w_ed_sec),
        .i_up    (w_tick | (w_ed_sec & inc)),
        .i_down  (w_ed_sec & dec),
        .o_q     (w_sec),
        .o_carry (w_sec_co)
    );

    rtc_wrap_cnt #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_sec_c | w_ed_min),
        .i_up    (w_sec_c | (w_ed_min & inc)),
        .i_down  (w_ed_min & dec),
        .o_q     (w_min),
        .o_carry (w_min_co)
    );

    rtc_wrap_cnt #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_min_c | w_ed_hour),
        .i_up    (w_min_c | (w_ed_hour & inc)),
        .i_down  (w_ed_hour & dec),
        .o_q     (w_hour),
        .o_carry (w_hour_co)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_day  <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_wrap <= w_hour_c;
            if (w_hour_c) begin
                r_day <= r_day + DAY_W'(1);
            end
        end
    end

    assign sec      = w_sec;
    assign min      = w_min;
    assign hour     = w_hour;
    assign day      = r_day;
    assign tick_1hz = r_tick;
    assign day_wrap = r_wrap;

`ifdef RTC_ALARM_EN
    logic [MIN_W-1:0]  w_min_nxt;
    logic [HOUR_W-1:0] w_hour_nxt;
    logic              w_alarm_hit;
    logic              r_alarm;

    // Fires only on a tick that lands on second 0 of the alarm minute.
    assign w_min_nxt   = (w_min == MIN_W'(MIN_MAX)) ? '0 : w_min + MIN_W'(1);
    assign w_hour_nxt  = w_min_c ?
                         ((w_hour == HOUR_W'(HOUR_MAX)) ? '0 : w_hour + HOUR_W'(1)) :
                         w_hour;
    assign w_alarm_hit = w_sec_c & alarm_en &
                         (w_min_nxt == alarm_min) & (w_hour_nxt == alarm_hour);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= w_alarm_hit;
        end
    end

    assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_rtc_core.sv
// tb_rtc_core: directed table, corner sequences and random stimulus for
// rtc_core, checked against a seconds-of-day reference model.
module tb_rtc_core;

    localparam int F     = 4;
    localparam int DAY_W = 3;
    localparam int DMOD  = 1 << DAY_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [1:0]       sel;
    logic             inc;
    logic             dec;
    logic [5:0]       sec;
    logic [5:0]       min;
    logic [4:0]       hour;
    logic [DAY_W-1:0] day;
    logic             tick_1hz;
    logic             day_wrap;
    logic             alarm;

    int al_en = 0;
    int al_h  = 0;
    int al_m  = 1;

`ifdef RTC_ALARM_EN
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    assign alarm_en   = (al_en != 0);
    assign alarm_hour = 5'(al_h);
    assign alarm_min  = 6'(al_m);
`else
    assign alarm = 1'b0;
`endif

    rtc_core #(.CLK_FREQ_HZ(F), .DAY_W(DAY_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .sel        (sel),
        .inc        (inc),
        .dec        (dec),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .day        (day),
        .tick_1hz   (tick_1hz),
        .day_wrap   (day_wrap)
`ifdef RTC_ALARM_EN
        ,
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm      (alarm)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_alarm = 0;

    // Reference model: time of day as seconds since midnight.
    int m_t   = 0;
    int m_day = 0;
    int m_ps  = 0;
    int e_tick = 0;
    int e_wrap = 0;
    int e_alarm = 0;

    typedef struct {
        logic       r;
        logic [1:0] s;
        logic       i;
        logic       d;
        int         n;
        int         e_sec;
        int         e_min;
        int         e_hour;
        int         e_day;
    } vec_t;

    vec_t tab[15];

    task automatic model_reset();
        m_t = 0; m_day = 0; m_ps = 0;
        e_tick = 0; e_wrap = 0; e_alarm = 0;
    endtask

    task automatic model_edge(input logic r, input logic [1:0] s,
                              input logic i, input logic d);
        int h, m, sc, dl;
        e_tick = 0; e_wrap = 0; e_alarm = 0;
        if (s == 2'd0) begin
            if (r) begin
                if (m_ps == F - 1) begin
                    m_ps = 0;
                    e_tick = 1;
                    m_t = m_t + 1;
                    if (m_t == 86400) begin
                        m_t = 0;
                        m_day = (m_day + 1) % DMOD;
                        e_wrap = 1;
                    end
                    if (al_en != 0 && m_t % 60 == 0 &&
                        m_t / 3600 == al_h && (m_t / 60) % 60 == al_m)
                        e_alarm = 1;
                end else begin
                    m_ps = m_ps + 1;
                end
            end
        end else begin
            m_ps = 0;
            if (i != d) begin
                dl = i ? 1 : -1;
                h  = m_t / 3600;
                m  = (m_t / 60) % 60;
                sc = m_t % 60;
                case (s)
                    2'd1:    sc = (sc + dl + 60) % 60;
                    2'd2:    m  = (m + dl + 60) % 60;
                    default: h  = (h + dl + 24) % 24;
                endcase
                m_t = h * 3600 + m * 60 + sc;
            end
        end
    endtask

    task automatic check_model(input string nm);
        int es, em, eh;
        es = m_t % 60;
        em = (m_t / 60) % 60;
        eh = m_t / 3600;
        n_chk++;
        if (int'(sec) != es || int'(min) != em || int'(hour) != eh ||
            int'(day) != m_day || int'(tick_1hz) != e_tick ||
            int'(day_wrap) != e_wrap || int'(alarm) != e_alarm) begin
            n_err++;
            $display("FAIL %s @%0t got %0d:%0d:%0d d%0d t%0b w%0b a%0b want %0d:%0d:%0d d%0d t%0d w%0d a%0d",
                     nm, $time, hour, min, sec, day, tick_1hz, day_wrap, alarm,
                     eh, em, es, m_day, e_tick, e_wrap, e_alarm);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] s,
                        input logic i, input logic d);
        run = r; sel = s; inc = i; dec = d;
        @(posedge clk);
        model_edge(r, s, i, d);
        #1;
        check_model("cycle");
        if (alarm) n_alarm++;
        inc = 1'b0;
        dec = 1'b0;
    endtask

    task automatic preload_235959();
        step(1'b1, 2'd3, 1'b0, 1'b1);
        step(1'b1, 2'd2, 1'b0, 1'b1);
        step(1'b1, 2'd1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [1:0] cur_sel;
        vec_t v;

        tab[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8,  2,  0,  0, 0};
        tab[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 10, 2,  0,  0, 0};
        tab[2]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1,  2,  0,  0, 0};
        tab[3]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1,  2,  0,  0, 0};
        tab[4]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1,  1,  0,  0, 0};
        tab[5]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1,  1, 59,  0, 0};
        tab[6]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1,  1, 59, 23, 0};
        tab[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1,  0, 59, 23, 0};
        tab[8]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1, 59, 59, 23, 0};
        tab[9]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3, 59, 59, 23, 0};
        tab[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 1,  0,  0,  0, 1};
        tab[11] = '{1'b1, 2'd3, 1'b0, 1'b1, 1,  0,  0, 23, 1};
        tab[12] = '{1'b1, 2'd3, 1'b1, 1'b0, 1,  0,  0,  0, 1};
        tab[13] = '{1'b1, 2'd2, 1'b0, 1'b1, 1,  0, 59,  0, 1};
        tab[14] = '{1'b1, 2'd2, 1'b1, 1'b0, 1,  0,  0,  0, 1};

        rst = 1'b0; run = 1'b0; sel = 2'd0; inc = 1'b0; dec = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        #8;
        rst = 1'b1;

        for (int k = 0; k < 15; k++) begin
            v = tab[k];
            for (int c = 0; c < v.n; c++)
                step(v.r, v.s, (c == 0) ? v.i : 1'b0, (c == 0) ? v.d : 1'b0);
            check_val($sformatf("tab%0d_sec", k), int'(sec), v.e_sec);
            check_val($sformatf("tab%0d_min", k), int'(min), v.e_min);
            check_val($sformatf("tab%0d_hour", k), int'(hour), v.e_hour);
            check_val($sformatf("tab%0d_day", k), int'(day), v.e_day);
        end

        for (int c = 0; c < 6; c++) step(1'b1, 2'd0, 1'b0, 1'b0);
        check_val("pre_rst_sec", int'(sec), 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        #2;
        rst = 1'b1;

        for (int w = 1; w <= DMOD; w++) begin
            preload_235959();
            for (int c = 0; c < F; c++) step(1'b1, 2'd0, 1'b0, 1'b0);
            check_val($sformatf("daywrap%0d", w), int'(day), w % DMOD);
        end

`ifdef RTC_ALARM_EN
        al_en = 1; al_h = 0; al_m = 1;
        n_alarm = 0;
        step(1'b1, 2'd1, 1'b0, 1'b1);
        for (int c = 0; c < F; c++) step(1'b1, 2'd0, 1'b0, 1'b0);
        check_val("alarm_tick", n_alarm, 1);
        step(1'b1, 2'd2, 1'b0, 1'b1);
        step(1'b1, 2'd2, 1'b1, 1'b0);
        check_val("alarm_set", n_alarm, 1);
`endif

        cur_sel = 2'd0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0)
                cur_sel = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            step($urandom_range(0, 7) != 0, cur_sel,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
